fifo_stream_reader: RTL and testbench



---
 rtl/fifo_reader_pkg.sv | 14 +
 rtl/fifo_stream_reader_skid_buf.sv | 56 +++++
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the sync_fifo_16_16 read-side stream master.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int FIFO_DATA_WIDTH = 16;
    localparam int FIFO_BUF_DEPTH  = 3;
    localparam int FIFO_CNT_WIDTH  = 16;

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Circular skid buffer: pushes land at tail, head entry is presented until popped.
module skid_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BUF_DEPTH  = FIFO_BUF_DEPTH,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occupancy
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok = pop && (occupancy != '0);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push)
                tail <= ptr_next(tail);
            if (pop_ok)
                head <= ptr_next(head);
            case ({push, pop_ok})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage is data-only; stale entries are never visible because head_data is gated.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= push_data;
    end

    assign head_data = (occupancy != '0) ? mem[head] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains sync_fifo_16_16 into a valid/ready stream at one word per cycle.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BUF_DEPTH  = FIFO_BUF_DEPTH,
    parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic             inflight;
    logic             issue_en;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W:0]   committed;
    logic             handshake;

    always_ff @(posedge clk) begin
        if (!rst_)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // STOP lasts one cycle: no reads are issued there, so any word still in
    // flight lands during that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (!en) state_nxt = (inflight || fifo_read) ? STOP : IDLE;
            STOP: state_nxt = en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue_en = (state == RUN);
    end

    // Reserve a buffer slot for every word already requested so the landing
    // word always has room, independent of m_ready.
    assign committed = {1'b0, occupancy} + (OCC_W + 1)'(inflight);
    assign fifo_read = issue_en && !fifo_empty && (committed < (OCC_W + 1)'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_)
            inflight <= 1'b0;
        else
            inflight <= fifo_read;
    end

    skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_      (rst_),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (handshake),
        .head_data (m_data),
        .occupancy (occupancy)
    );

    assign m_valid   = (occupancy != '0);
    assign handshake = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (!rst_)
            word_count <= '0;
        else if (handshake)
            word_count <= word_count + CNT_WIDTH'(1);
    end

    assign busy = (state != IDLE) || (occupancy != '0) || inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural one-cycle-latency FIFO.
module tb_fifo_stream_reader;
    import fifo_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic        en;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_read;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        flush = 1'b0;

    int          rd_cnt = 0;
    int          out_n = 0;
    logic [15:0] out_log [256];
    logic [15:0] last_out = '0;

    int rd_base;
    int out_base;

    fifo_stream_reader #(
        .DATA_WIDTH (16),
        .BUF_DEPTH  (3),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush)
            rd_ptr <= wr_ptr;
        else if (fifo_read && !fifo_empty) begin
            fifo_data_out <= fifo_mem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("no_read_when_empty", {31'd0, fifo_read && fifo_empty}, 32'd0);
        check("occupancy_bound", {31'd0, dut.u_buf.occupancy <= 2'd3}, 32'd1);
        if (fifo_read && !fifo_empty)
            rd_cnt++;
        if (m_valid && m_ready) begin
            if (out_n < 256)
                out_log[out_n] = m_data;
            last_out = m_data;
            out_n++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        fifo_mem[wr_ptr % 64] = v;
        wr_ptr++;
    endtask

    initial begin
        rst_    = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        for (int v = 2; v <= 9; v++) push(16'(v));

        // Reset held for two edges with en=1 and a non-empty FIFO.
        for (int r = 0; r < 2; r++) begin
            cyc();
            check("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
            check("rst_m_valid", {31'd0, m_valid}, 32'd0);
            check("rst_word_count", {16'd0, word_count}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_m_data", {16'd0, m_data}, 32'd0);
        end
        check("rst_fifo_untouched", 32'(wr_ptr - rd_ptr), 32'd8);
        rst_ = 1'b1;

        // Streaming: reads on 8 consecutive cycles, data two cycles behind.
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("stream_fifo_read", {31'd0, fifo_read}, (i < 8) ? 32'd1 : 32'd0);
            if (i < 2) begin
                check("stream_startup_valid", {31'd0, m_valid}, 32'd0);
            end else begin
                check("stream_valid", {31'd0, m_valid}, 32'd1);
                check("stream_data", {16'd0, m_data}, 32'(i));
            end
        end
        cyc();
        check("stream_drained_valid", {31'd0, m_valid}, 32'd0);
        check("stream_word_count", {16'd0, word_count}, 32'd8);
        check("stream_read_total", 32'(rd_cnt), 32'd8);
        check("stream_out_total", 32'(out_n), 32'd8);
        check("stream_busy_run", {31'd0, busy}, 32'd1);

        // Backpressure: only three reads fit, head held until m_ready rises.
        m_ready = 1'b0;
        rd_base = rd_cnt;
        for (int v = 2; v <= 9; v++) push(16'(v));
        for (int k = 0; k < 6; k++) cyc();
        check("bp_read_count", 32'(rd_cnt - rd_base), 32'd3);
        check("bp_occupancy", {30'd0, dut.u_buf.occupancy}, 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
            check("bp_hold_data", {16'd0, m_data}, 32'd2);
            check("bp_no_read", {31'd0, fifo_read}, 32'd0);
            cyc();
        end
        out_base = out_n;
        m_ready  = 1'b1;
        for (int k = 0; k < 12; k++) cyc();
        check("bp_out_total", 32'(out_n - out_base), 32'd8);
        for (int k = 0; k < 8; k++)
            check("bp_order", {16'd0, out_log[out_base + k]}, 32'(k + 2));
        check("bp_word_count", {16'd0, word_count}, 32'd16);

        // Stop mid-stream with a read in flight.
        rd_base = rd_cnt;
        for (int v = 16; v < 20; v++) push(16'(v));
        cyc();
        en = 1'b0;
        check("stop_last_read", {31'd0, fifo_read}, 32'd1);
        cyc();
        check("stop_state", {30'd0, dut.state}, {30'd0, STOP});
        check("stop_no_read", {31'd0, fifo_read}, 32'd0);
        check("stop_data0", {16'd0, m_data}, 32'h10);
        cyc();
        check("stop_idle", {30'd0, dut.state}, {30'd0, IDLE});
        check("stop_landed_data", {16'd0, m_data}, 32'h11);
        check("stop_busy_draining", {31'd0, busy}, 32'd1);
        cyc();
        check("stop_drained_valid", {31'd0, m_valid}, 32'd0);
        check("stop_busy_low", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) cyc();
        check("stop_read_total", 32'(rd_cnt - rd_base), 32'd2);
        check("stop_word_count", {16'd0, word_count}, 32'd18);
        flush = 1'b1;
        cyc();
        flush = 1'b0;

        // Empty FIFO, then one word.
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("empty_no_read", {31'd0, fifo_read}, 32'd0);
            check("empty_no_valid", {31'd0, m_valid}, 32'd0);
        end
        out_base = out_n;
        push(16'hA5A5);
        for (int k = 0; k < 5; k++) cyc();
        check("single_out_total", 32'(out_n - out_base), 32'd1);
        check("single_data", {16'd0, out_log[out_base]}, 32'hA5A5);
        check("single_word_count", {16'd0, word_count}, 32'd19);

        // Bulk transfer up to 16'hFFFF, then one more word wraps the counter.
        wr_ptr = wr_ptr + 65516;
        for (int k = 0; k < 66000 && word_count !== 16'hFFFF; k++) cyc();
        check("bulk_reached_ffff", {16'd0, word_count}, 32'hFFFF);
        for (int k = 0; k < 4; k++) cyc();
        check("bulk_no_extra", {16'd0, word_count}, 32'hFFFF);
        check("bulk_drained", {31'd0, m_valid}, 32'd0);
        push(16'h0BEE);
        for (int k = 0; k < 5; k++) cyc();
        check("wrap_word_count", {16'd0, word_count}, 32'd0);
        check("wrap_last_data", {16'd0, last_out}, 32'h0BEE);

        // Reset with two words buffered.
        m_ready = 1'b0;
        push(16'h0021);
        push(16'h0022);
        for (int k = 0; k < 4; k++) cyc();
        check("mid_occupancy", {30'd0, dut.u_buf.occupancy}, 32'd2);
        check("mid_head", {16'd0, m_data}, 32'h21);
        rst_ = 1'b0;
        cyc();
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_data", {16'd0, m_data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_occupancy", {30'd0, dut.u_buf.occupancy}, 32'd0);
        rst_ = 1'b1;
        m_ready = 1'b1;
        cyc();
        check("mid_after_valid", {31'd0, m_valid}, 32'd0);
        check("mid_after_count", {16'd0, word_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
